// File: rtl/hb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// hb_ram_arbiter -- two-client round-robin arbiter for the history-buffer RAM
// Revision: 1.0
// ============================================================================

module hb_ram_arbiter_chan #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic c0_req_vld,
    input  logic c1_req_vld,
    output logic c0_req_rdy,
    output logic c1_req_rdy,
    output logic gnt,
    output logic ram_req_vld,
    input  logic ram_req_rdy,
    input  logic ram_resp_vld,
    output logic ram_resp_rdy,
    output logic c0_resp_vld,
    output logic c1_resp_vld,
    input  logic c0_resp_rdy,
    input  logic c1_resp_rdy
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam logic [PW:0] c_ptr_one = {{PW{1'b0}}, 1'b1};

    logic [PW:0]                r_wptr;
    logic [PW:0]                r_rptr;
    logic [MAX_OUTSTANDING-1:0] r_owner;
    logic                       r_prio;

    logic w_full;
    logic w_empty;
    logic w_any;
    logic w_gnt;
    logic w_head;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_any   = c0_req_vld | c1_req_vld;
    // Lone requester wins outright; on contention the favoured client wins.
    assign w_gnt   = (c0_req_vld & c1_req_vld) ? r_prio : c1_req_vld;
    assign w_head  = r_owner[r_rptr[PW-1:0]];

    assign gnt          = w_gnt;
    assign ram_req_vld  = ~rst & w_any & ~w_full;
    assign c0_req_rdy   = ~rst & ~w_full & ram_req_rdy & c0_req_vld & ~w_gnt;
    assign c1_req_rdy   = ~rst & ~w_full & ram_req_rdy & c1_req_vld & w_gnt;

    assign c0_resp_vld  = ~rst & ram_resp_vld & ~w_empty & ~w_head;
    assign c1_resp_vld  = ~rst & ram_resp_vld & ~w_empty & w_head;
    assign ram_resp_rdy = ~rst & ~w_empty & (w_head ? c1_resp_rdy : c0_resp_rdy);

    assign w_push = ram_req_vld & ram_req_rdy;
    assign w_pop  = ram_resp_vld & ram_resp_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_owner <= '0;
            r_prio  <= 1'b0;
        end else begin
            if (w_push) begin
                r_owner[r_wptr[PW-1:0]] <= w_gnt;
                r_wptr                  <= r_wptr + c_ptr_one;
                r_prio                  <= ~w_gnt;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
        end
    end
endmodule

module hb_ram_arbiter #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 8,
    parameter int NUM_PARTITIONS  = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [ADDR_WIDTH+DATA_WIDTH+NUM_PARTITIONS-1:0] c0_wr_req_data,
    input  logic                                         c0_wr_req_vld,
    output logic                                         c0_wr_req_rdy,
    output logic                                         c0_wr_resp_vld,
    input  logic                                         c0_wr_resp_rdy,
    input  logic [ADDR_WIDTH+NUM_PARTITIONS-1:0]         c0_rd_req_data,
    input  logic                                         c0_rd_req_vld,
    output logic                                         c0_rd_req_rdy,
    output logic [DATA_WIDTH-1:0]                        c0_rd_resp_data,
    output logic                                         c0_rd_resp_vld,
    input  logic                                         c0_rd_resp_rdy,
    input  logic [ADDR_WIDTH+DATA_WIDTH+NUM_PARTITIONS-1:0] c1_wr_req_data,
    input  logic                                         c1_wr_req_vld,
    output logic                                         c1_wr_req_rdy,
    output logic                                         c1_wr_resp_vld,
    input  logic                                         c1_wr_resp_rdy,
    input  logic [ADDR_WIDTH+NUM_PARTITIONS-1:0]         c1_rd_req_data,
    input  logic                                         c1_rd_req_vld,
    output logic                                         c1_rd_req_rdy,
    output logic [DATA_WIDTH-1:0]                        c1_rd_resp_data,
    output logic                                         c1_rd_resp_vld,
    input  logic                                         c1_rd_resp_rdy,
    output logic [ADDR_WIDTH+DATA_WIDTH+NUM_PARTITIONS-1:0] ram_wr_req_data,
    output logic                                         ram_wr_req_vld,
    input  logic                                         ram_wr_req_rdy,
    input  logic                                         ram_wr_resp_vld,
    output logic                                         ram_wr_resp_rdy,
    output logic [ADDR_WIDTH+NUM_PARTITIONS-1:0]         ram_rd_req_data,
    output logic                                         ram_rd_req_vld,
    input  logic                                         ram_rd_req_rdy,
    input  logic [DATA_WIDTH-1:0]                        ram_rd_resp_data,
    input  logic                                         ram_rd_resp_vld,
    output logic                                         ram_rd_resp_rdy
);
    logic w_wr_gnt;
    logic w_rd_gnt;

    hb_ram_arbiter_chan #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_wr (
        .clk          (clk),
        .rst          (rst),
        .c0_req_vld   (c0_wr_req_vld),
        .c1_req_vld   (c1_wr_req_vld),
        .c0_req_rdy   (c0_wr_req_rdy),
        .c1_req_rdy   (c1_wr_req_rdy),
        .gnt          (w_wr_gnt),
        .ram_req_vld  (ram_wr_req_vld),
        .ram_req_rdy  (ram_wr_req_rdy),
        .ram_resp_vld (ram_wr_resp_vld),
        .ram_resp_rdy (ram_wr_resp_rdy),
        .c0_resp_vld  (c0_wr_resp_vld),
        .c1_resp_vld  (c1_wr_resp_vld),
        .c0_resp_rdy  (c0_wr_resp_rdy),
        .c1_resp_rdy  (c1_wr_resp_rdy)
    );

    hb_ram_arbiter_chan #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_rd (
        .clk          (clk),
        .rst          (rst),
        .c0_req_vld   (c0_rd_req_vld),
        .c1_req_vld   (c1_rd_req_vld),
        .c0_req_rdy   (c0_rd_req_rdy),
        .c1_req_rdy   (c1_rd_req_rdy),
        .gnt          (w_rd_gnt),
        .ram_req_vld  (ram_rd_req_vld),
        .ram_req_rdy  (ram_rd_req_rdy),
        .ram_resp_vld (ram_rd_resp_vld),
        .ram_resp_rdy (ram_rd_resp_rdy),
        .c0_resp_vld  (c0_rd_resp_vld),
        .c1_resp_vld  (c1_rd_resp_vld),
        .c0_resp_rdy  (c0_rd_resp_rdy),
        .c1_resp_rdy  (c1_rd_resp_rdy)
    );

    assign ram_wr_req_data = w_wr_gnt ? c1_wr_req_data : c0_wr_req_data;
    assign ram_rd_req_data = w_rd_gnt ? c1_rd_req_data : c0_rd_req_data;

    // Read data goes to both clients; only the per-client vld qualifies it.
    assign c0_rd_resp_data = ram_rd_resp_data;
    assign c1_rd_resp_data = ram_rd_resp_data;
endmodule
`default_nettype wire

// File: tb/tb_hb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_hb_ram_arbiter -- randomized bench with queue-based reference model
// Revision: 1.0
// ============================================================================
module tb_hb_ram_arbiter;
    localparam int MAX_OUT = 4;
    localparam int W = 25;
    localparam int R = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [W-1:0] c0_wr_req_data, c1_wr_req_data, ram_wr_req_data;
    logic         c0_wr_req_vld, c1_wr_req_vld, c0_wr_req_rdy, c1_wr_req_rdy;
    logic         c0_wr_resp_vld, c1_wr_resp_vld, c0_wr_resp_rdy, c1_wr_resp_rdy;
    logic [R-1:0] c0_rd_req_data, c1_rd_req_data, ram_rd_req_data;
    logic         c0_rd_req_vld, c1_rd_req_vld, c0_rd_req_rdy, c1_rd_req_rdy;
    logic [7:0]   c0_rd_resp_data, c1_rd_resp_data, ram_rd_resp_data;
    logic         c0_rd_resp_vld, c1_rd_resp_vld, c0_rd_resp_rdy, c1_rd_resp_rdy;
    logic         ram_wr_req_vld, ram_wr_req_rdy, ram_wr_resp_vld, ram_wr_resp_rdy;
    logic         ram_rd_req_vld, ram_rd_req_rdy, ram_rd_resp_vld, ram_rd_resp_rdy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: owner queues, favoured client, RAM contents, RAM read returns.
    bit         m_wr_own[$];
    bit         m_rd_own[$];
    bit         m_wr_prio;
    bit         m_rd_prio;
    logic [7:0] mem [16];
    logic [7:0] rd_pend[$];

    always #5 clk = ~clk;

    hb_ram_arbiter #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .NUM_PARTITIONS(1), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .c0_wr_req_data(c0_wr_req_data), .c0_wr_req_vld(c0_wr_req_vld), .c0_wr_req_rdy(c0_wr_req_rdy),
        .c0_wr_resp_vld(c0_wr_resp_vld), .c0_wr_resp_rdy(c0_wr_resp_rdy),
        .c0_rd_req_data(c0_rd_req_data), .c0_rd_req_vld(c0_rd_req_vld), .c0_rd_req_rdy(c0_rd_req_rdy),
        .c0_rd_resp_data(c0_rd_resp_data), .c0_rd_resp_vld(c0_rd_resp_vld), .c0_rd_resp_rdy(c0_rd_resp_rdy),
        .c1_wr_req_data(c1_wr_req_data), .c1_wr_req_vld(c1_wr_req_vld), .c1_wr_req_rdy(c1_wr_req_rdy),
        .c1_wr_resp_vld(c1_wr_resp_vld), .c1_wr_resp_rdy(c1_wr_resp_rdy),
        .c1_rd_req_data(c1_rd_req_data), .c1_rd_req_vld(c1_rd_req_vld), .c1_rd_req_rdy(c1_rd_req_rdy),
        .c1_rd_resp_data(c1_rd_resp_data), .c1_rd_resp_vld(c1_rd_resp_vld), .c1_rd_resp_rdy(c1_rd_resp_rdy),
        .ram_wr_req_data(ram_wr_req_data), .ram_wr_req_vld(ram_wr_req_vld), .ram_wr_req_rdy(ram_wr_req_rdy),
        .ram_wr_resp_vld(ram_wr_resp_vld), .ram_wr_resp_rdy(ram_wr_resp_rdy),
        .ram_rd_req_data(ram_rd_req_data), .ram_rd_req_vld(ram_rd_req_vld), .ram_rd_req_rdy(ram_rd_req_rdy),
        .ram_rd_resp_data(ram_rd_resp_data), .ram_rd_resp_vld(ram_rd_resp_vld), .ram_rd_resp_rdy(ram_rd_resp_rdy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    // What the arbitration rules say one channel must do this cycle.
    function automatic void chan_eval(
        input bit v0, input bit v1, input bit prio, input int cnt, input bit head,
        input bit ram_rdy, input bit rsp_vld, input bit r0, input bit r1,
        output bit win, output bit ram_vld, output bit rdy0, output bit rdy1,
        output bit rv0, output bit rv1, output bit ram_rr);
        bit full;
        bit empty;
        full    = (cnt == MAX_OUT);
        empty   = (cnt == 0);
        win     = (v0 && v1) ? prio : v1;
        ram_vld = (v0 || v1) && !full;
        rdy0    = ram_vld && ram_rdy && !win;
        rdy1    = ram_vld && ram_rdy && win;
        rv0     = rsp_vld && !empty && !head;
        rv1     = rsp_vld && !empty && head;
        ram_rr  = !empty && (head ? r1 : r0);
    endfunction

    function automatic logic [11:0] hs_outputs();
        return {c0_wr_req_rdy, c1_wr_req_rdy, c0_wr_resp_vld, c1_wr_resp_vld,
                c0_rd_req_rdy, c1_rd_req_rdy, c0_rd_resp_vld, c1_rd_resp_vld,
                ram_wr_req_vld, ram_wr_resp_rdy, ram_rd_req_vld, ram_rd_resp_rdy};
    endfunction

    task automatic idle_inputs();
        c0_wr_req_vld = 0; c1_wr_req_vld = 0; c0_rd_req_vld = 0; c1_rd_req_vld = 0;
        ram_wr_resp_vld = 0; ram_rd_resp_vld = 0;
    endtask

    task automatic step(input int pv0, input int pv1, input int pram, input int presp,
                        input int pr0, input int pr1);
        bit wwin, wvld, wr0, wr1, wv0, wv1, wrr;
        bit rwin, rvld, rr0, rr1, rv0, rv1, rrr;
        logic [W-1:0] wd;
        logic [R-1:0] rq;
        @(posedge clk); #1;
        c0_wr_req_vld  = pct(pv0);  c1_wr_req_vld  = pct(pv1);
        c0_rd_req_vld  = pct(pv0);  c1_rd_req_vld  = pct(pv1);
        c0_wr_req_data = {16'($urandom_range(15)), 8'($urandom), 1'($urandom)};
        c1_wr_req_data = {16'($urandom_range(15)), 8'($urandom), 1'($urandom)};
        c0_rd_req_data = {16'($urandom_range(15)), 1'($urandom)};
        c1_rd_req_data = {16'($urandom_range(15)), 1'($urandom)};
        ram_wr_req_rdy = pct(pram); ram_rd_req_rdy = pct(pram);
        ram_wr_resp_vld  = (m_wr_own.size() > 0) && pct(presp);
        ram_rd_resp_vld  = (rd_pend.size() > 0) && pct(presp);
        ram_rd_resp_data = (rd_pend.size() > 0) ? rd_pend[0] : 8'($urandom);
        c0_wr_resp_rdy = pct(pr0); c1_wr_resp_rdy = pct(pr1);
        c0_rd_resp_rdy = pct(pr0); c1_rd_resp_rdy = pct(pr1);
        #1;
        chan_eval(c0_wr_req_vld, c1_wr_req_vld, m_wr_prio, m_wr_own.size(),
                  (m_wr_own.size() > 0) ? m_wr_own[0] : 1'b0, ram_wr_req_rdy, ram_wr_resp_vld,
                  c0_wr_resp_rdy, c1_wr_resp_rdy, wwin, wvld, wr0, wr1, wv0, wv1, wrr);
        chan_eval(c0_rd_req_vld, c1_rd_req_vld, m_rd_prio, m_rd_own.size(),
                  (m_rd_own.size() > 0) ? m_rd_own[0] : 1'b0, ram_rd_req_rdy, ram_rd_resp_vld,
                  c0_rd_resp_rdy, c1_rd_resp_rdy, rwin, rvld, rr0, rr1, rv0, rv1, rrr);

        check_eq("wr_req", 32'({c0_wr_req_rdy, c1_wr_req_rdy, ram_wr_req_vld}), 32'({wr0, wr1, wvld}));
        check_eq("rd_req", 32'({c0_rd_req_rdy, c1_rd_req_rdy, ram_rd_req_vld}), 32'({rr0, rr1, rvld}));
        check_eq("wr_resp", 32'({c0_wr_resp_vld, c1_wr_resp_vld, ram_wr_resp_rdy}), 32'({wv0, wv1, wrr}));
        check_eq("rd_resp", 32'({c0_rd_resp_vld, c1_rd_resp_vld, ram_rd_resp_rdy}), 32'({rv0, rv1, rrr}));
        wd = wwin ? c1_wr_req_data : c0_wr_req_data;
        rq = rwin ? c1_rd_req_data : c0_rd_req_data;
        if (wvld) check_eq("wr_data", 32'(ram_wr_req_data), 32'(wd));
        if (rvld) check_eq("rd_addr", 32'(ram_rd_req_data), 32'(rq));
        if (rv0)  check_eq("rd_data0", 32'(c0_rd_resp_data), 32'(rd_pend[0]));
        if (rv1)  check_eq("rd_data1", 32'(c1_rd_resp_data), 32'(rd_pend[0]));

        if (ram_wr_resp_vld && wrr) void'(m_wr_own.pop_front());
        if (ram_rd_resp_vld && rrr) void'(rd_pend.pop_front());
        if (ram_rd_resp_vld && rrr) void'(m_rd_own.pop_front());
        if (wvld && ram_wr_req_rdy) begin
            m_wr_own.push_back(wwin);
            m_wr_prio = !wwin;
            if (wd[0]) mem[wd[12:9]] = wd[8:1];
        end
        if (rvld && ram_rd_req_rdy) begin
            m_rd_own.push_back(rwin);
            m_rd_prio = !rwin;
            rd_pend.push_back(mem[rq[4:1]]);
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        c0_wr_req_vld = 1; c1_wr_req_vld = 1; c0_rd_req_vld = 1; c1_rd_req_vld = 1;
        ram_wr_req_rdy = 1; ram_rd_req_rdy = 1;
        ram_wr_resp_vld = 1; ram_rd_resp_vld = 1;
        c0_wr_resp_rdy = 1; c1_wr_resp_rdy = 1; c0_rd_resp_rdy = 1; c1_rd_resp_rdy = 1;
        #1 rst = 1'b1;
        #1 check_eq("rst_async", 32'(hs_outputs()), 32'd0);
        m_wr_own.delete(); m_rd_own.delete(); rd_pend.delete();
        m_wr_prio = 0; m_rd_prio = 0;
        @(posedge clk); #1 idle_inputs();
        @(posedge clk); #1 rst = 1'b0;
        // A stray RAM response right after release must not be acknowledged.
        ram_wr_resp_vld = 1; ram_rd_resp_vld = 1;
        #1 check_eq("empty_after_rst", 32'({ram_wr_resp_rdy, ram_rd_resp_rdy, c0_wr_resp_vld,
                    c1_wr_resp_vld, c0_rd_resp_vld, c1_rd_resp_vld}), 32'd0);
        ram_wr_resp_vld = 0; ram_rd_resp_vld = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        m_wr_prio = 0; m_rd_prio = 0;
        c0_wr_req_data = '0; c1_wr_req_data = '0; c0_rd_req_data = '0; c1_rd_req_data = '0;
        ram_rd_resp_data = '0;
        c0_wr_req_vld = 1; c1_wr_req_vld = 1; c0_rd_req_vld = 1; c1_rd_req_vld = 1;
        ram_wr_req_rdy = 1; ram_rd_req_rdy = 1; ram_wr_resp_vld = 1; ram_rd_resp_vld = 1;
        c0_wr_resp_rdy = 1; c1_wr_resp_rdy = 1; c0_rd_resp_rdy = 1; c1_rd_resp_rdy = 1;
        #1 check_eq("rst_init", 32'(hs_outputs()), 32'd0);
        @(posedge clk); #1 idle_inputs();
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 24; i++) step(100, 0, 100, 60, 100, 100);  // c0 alone
        for (int i = 0; i < 16; i++) step(100, 100, 100, 70, 100, 100); // contention
        for (int i = 0; i < 8; i++)  step(100, 100, 100, 0, 100, 100);  // fill to full
        for (int i = 0; i < 8; i++)  step(100, 100, 100, 100, 100, 100);
        for (int i = 0; i < 20; i++) step(60, 60, 100, 100, 100, 0);    // c1 stalls head
        for (int i = 0; i < 10; i++) step(60, 60, 100, 100, 100, 100);
        for (int i = 0; i < 30; i++) step(100, 100, 100, 100, 100, 100); // push+pop each cycle
        for (int i = 0; i < 400; i++) step(50, 50, 70, 60, 70, 70);
        for (int i = 0; i < 3; i++)  step(100, 0, 100, 0, 100, 100);    // reads in flight
        reset_pulse();
        for (int i = 0; i < 16; i++) step(100, 100, 100, 70, 100, 100);
        for (int i = 0; i < 200; i++) step(50, 50, 70, 60, 70, 70);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hb_ram_arbiter.md
# hb_ram_arbiter

Two-client arbiter for the history-buffer RAM (`sdpram_xls_chan`) used by the DBE LZ4 blocks. It shares one RAM instance between two channel-level requesters, for example a decoder engine and a host/debug preload port. Write and read channels are arbitrated independently with round-robin fairness. Responses are steered back to the issuing client through per-channel ownership FIFOs.

## Interface
Parameters:
- ADDR_WIDTH, 16, RAM address width
- DATA_WIDTH, 8, RAM data width
- NUM_PARTITIONS, 1, write-mask partition bits; same packing as the RAM
- MAX_OUTSTANDING, 4, in-flight requests per channel; power of two, ≥2

Ports (W = ADDR_WIDTH+DATA_WIDTH+NUM_PARTITIONS, R = ADDR_WIDTH+NUM_PARTITIONS):
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cN_wr_req_data  in  W  client N write request (N = 0, 1); passed unmodified
- cN_wr_req_vld / cN_wr_req_rdy  in/out  1  client N write-request handshake
- cN_wr_resp_vld / cN_wr_resp_rdy  out/in  1  client N write-completion handshake (no data)
- cN_rd_req_data  in  R  client N read request
- cN_rd_req_vld / cN_rd_req_rdy  in/out  1  client N read-request handshake
- cN_rd_resp_data  out  DATA_WIDTH  client N read data
- cN_rd_resp_vld / cN_rd_resp_rdy  out/in  1  client N read-response handshake
- ram_wr_req_data, ram_wr_req_vld, ram_wr_req_rdy  out/out/in  W/1/1  to RAM
- ram_wr_resp_vld, ram_wr_resp_rdy  in/out  1/1  from RAM
- ram_rd_req_data, ram_rd_req_vld, ram_rd_req_rdy  out/out/in  R/1/1  to RAM
- ram_rd_resp_data, ram_rd_resp_vld, ram_rd_resp_rdy  in/in/out  DATA_WIDTH/1/1  from RAM

## Operation
- Two identical channel units, WR and RD. Each holds:
  - `prio`: 1 bit, the client favoured on contention
  - an owner FIFO: MAX_OUTSTANDING entries × 1-bit client id, with read/write pointers of log2(MAX_OUTSTANDING)+1 bits
- Grant selection (combinational):
  - If only one client has vld high, that client wins.
  - If both have vld high, client `prio` wins.
  - If neither has vld high, there is no grant.
- Request forwarding:
  - ram_x_req_vld = granted-client vld & !fifo_full.
  - ram_x_req_data is a mux of the granted client's data.
  - Granted client rdy = ram_x_req_rdy & !fifo_full. The losing client's rdy is 0.
- On request handshake:
  - Push the granted client id into the owner FIFO.
  - Set `prio` to the other client (strict alternation under continuous contention).
  - `prio` is unchanged on cycles with no handshake.
- Response routing:
  - head = FIFO front entry.
  - cHead_x_resp_vld = ram_x_resp_vld & !fifo_empty. The other client's vld is 0.
  - ram_x_resp_rdy = !fifo_empty & cHead_x_resp_rdy.
  - Read data is broadcast to both clients' cN_rd_resp_data; only the vld output qualifies it.
- On response handshake: pop the FIFO.
- Push and pop may occur in the same cycle. Occupancy is then unchanged and pointers advance independently, wrapping modulo 2·MAX_OUTSTANDING.
- Full: grant rdy is 0 even when a pop occurs that cycle. There is no full-bypass, which avoids a combinational path from resp_rdy to req_rdy.
- Empty: ram_x_resp_rdy = 0 and both client resp vld = 0. A RAM response with an empty FIFO is a protocol violation; the arbiter holds it without acknowledging.
- WR and RD are fully independent. The RAM's own read-after-write ordering applies; the arbiter adds none.

## Timing
- Request path: zero-latency combinational pass-through. vld→vld and rdy→rdy contain no register.
- Response path: zero-latency combinational.
- Arbitration state updates on the clk edge following the handshake.
- Reset (asynchronous assert, synchronous-edge deassert by the system):
  - FIFOs empty, pointers = 0, both `prio` = 0 (client 0 favoured).
  - While rst = 1, every vld/rdy output is forced to 0 and data outputs are don't-care.
  - Reset mid-transaction discards all in-flight ownership. The RAM is reset on the same rst.
- After the first clk edge with rst = 0, requests are accepted if the RAM is ready.
- Throughput: one request per channel per cycle. Each client gets at least 1 of every 2 grants under contention.

## Test plan
- Single client: c0 issues writes to addresses 0x0000..0x0003 (data 0xA0..0xA3), then reads the same 4 addresses. Required: 4 wr_resp on c0, rd_resp data 0xA0..0xA3 in order, and no vld ever on c1.
- Contention: c0 and c1 both hold rd_req_vld for 8 cycles. Required grant order c0,c1,c0,c1,… starting with c0 after reset, and each response returns to the issuing client.
- Backpressure/full: RAM holds rd_resp_vld low while clients issue 6 reads (MAX_OUTSTANDING = 4). Required: exactly 4 accepted, then rdy = 0 to both clients; after one response pop, exactly one more request is accepted.
- Response stall: head owner c1 holds rd_resp_rdy = 0 while c0's response is next. Required: ram_rd_resp_rdy = 0, c0 sees no vld, and delivery proceeds in issue order once c1 accepts.
- Simultaneous push/pop at occupancy 2 for 10 cycles. Required: occupancy stays 2, no lost or duplicated responses, and the pointers wrap correctly past 7.
- Async reset pulse with 3 reads in flight. Required: all vld/rdy outputs drop to 0 immediately (same cycle, no clock edge needed), the FIFO is empty after release, and `prio` = c0.
